// File: rtl/instr_cycle_ctl.sv
// instr_cycle_ctl: 8-state instruction-cycle sequencer locked to the fetch strobe,
// driving registered PC/IR/ACC/memory/bus strobes and flagging fetch phase slips.
module instr_cycle_ctl #(
    parameter bit SYNC_CHECK = 1'b1,
    parameter int OP_W       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            load_ir,
    output logic            rd,
    output logic            wr,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            datactl_ena,
    output logic            halt,
    output logic            sync_err
);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALT} state_t;

    state_t          state_q, state_d;
    logic            fetch_q, rise, err_d, zero_q, zero_d, alu, s01, s45;
    logic [OP_W-1:0] op_q, op_d;

    always_comb begin
        rise    = fetch & ~fetch_q;
        op_d    = (state_q == S2) ? opcode : op_q;
        zero_d  = (state_q == S3) ? zero : zero_q;
        err_d   = sync_err;
        state_d = state_q;
        if (state_q == IDLE) begin
            state_d = rise ? S0 : IDLE;
        end else if (state_q != HALT) begin
            state_d = (state_q == S7) ? S0 : state_t'(state_q + 4'd1);
            // a rise belongs in S7 only: early rise resyncs, missing rise drops to IDLE
            if (SYNC_CHECK && (rise != (state_q == S7))) begin
                err_d   = 1'b1;
                state_d = rise ? S0 : IDLE;
            end
            if (state_q == S3 && op_q == OP_HLT) state_d = HALT;
        end
        alu = op_d inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
        s01 = state_d == S0 || state_d == S1;
        s45 = state_d == S4 || state_d == S5;
    end

    // strobes are decoded from the next state so they are registered yet cover the whole state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_q     <= 1'b0;
            op_q        <= '0;
            zero_q      <= 1'b0;
            sync_err    <= 1'b0;
            load_ir     <= 1'b0;
            rd          <= 1'b0;
            wr          <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            load_acc    <= 1'b0;
            datactl_ena <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch;
            op_q        <= op_d;
            zero_q      <= zero_d;
            sync_err    <= err_d;
            load_ir     <= s01;
            rd          <= s01 || (s45 && alu);
            wr          <= state_d == S5 && op_d == OP_STO;
            inc_pc      <= s01 || (s45 && op_d == OP_SKZ && zero_d);
            load_pc     <= s45 && op_d == OP_JMP;
            load_acc    <= state_d == S5 && alu;
            datactl_ena <= (s45 || state_d == S6) && op_d == OP_STO;
            halt        <= state_d == HALT;
        end
    end
endmodule
